// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction width, decoded field bundle.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    // Decoded fields of one instruction lane.
    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [31:0] imm;
    } fields_t;

    // Occupancy of the IF/ID stage: nothing, main only, main plus skid.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } occ_t;

endpackage

// File: rtl/if_id_fields.sv
// Combinational decode of one 32-bit instruction into its field bundle.
module if_id_fields
    import mips_pkg::*;
#(
    parameter bit ZEXT_LOGIC = 1'b1
) (
    input  logic [INSTR_W-1:0] instr,
    output fields_t            fields
);

    logic zext;

    // Split the instruction; logical immediates are zero-extended when enabled.
    always_comb begin
        fields       = '0;
        fields.op    = instr[31:26];
        fields.rs    = instr[25:21];
        fields.rt    = instr[20:16];
        fields.rd    = instr[15:11];
        fields.sa    = instr[10:6];
        fields.funct = instr[5:0];
        zext         = ZEXT_LOGIC && ((instr[31:26] == OP_ANDI) || (instr[31:26] == OP_ORI) ||
                                      (instr[31:26] == OP_XORI));
        fields.imm   = zext ? {16'b0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: decodes a fetch bundle on entry and holds it in a
// two-entry (main + skid) buffer with valid/ready handshakes and flush.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int unsigned LANES      = 1,
    parameter int unsigned PC_W       = 32,
    parameter bit          ZEXT_LOGIC = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W*LANES-1:0]   instr_in,
    input  logic [LANES-1:0]           lane_mask_in,
    input  logic [PC_W-1:0]            pcplus4_in,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           lane_valid,
    output logic [PC_W-1:0]            pcplus4_out,
    output logic [6*LANES-1:0]         op,
    output logic [6*LANES-1:0]         funct,
    output logic [5*LANES-1:0]         rs,
    output logic [5*LANES-1:0]         rt,
    output logic [5*LANES-1:0]         rd,
    output logic [5*LANES-1:0]         sa,
    output logic [32*LANES-1:0]        imm
);

    fields_t [LANES-1:0] in_fields;
    fields_t [LANES-1:0] m_fields_q;
    fields_t [LANES-1:0] s_fields_q;
    logic    [LANES-1:0] m_mask_q;
    logic    [LANES-1:0] s_mask_q;
    logic    [PC_W-1:0]  m_pc_q;
    logic    [PC_W-1:0]  s_pc_q;
    occ_t                state_q;
    occ_t                state_d;
    logic                in_ready_q;
    logic                accept;
    logic                deliver;
    logic                load_m_in;
    logic                load_m_s;
    logic                load_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        if_id_fields #(
            .ZEXT_LOGIC (ZEXT_LOGIC)
        ) u_fields (
            .instr  (instr_in[INSTR_W*g +: INSTR_W]),
            .fields (in_fields[g])
        );

        assign op[6*g +: 6]     = m_fields_q[g].op;
        assign funct[6*g +: 6]  = m_fields_q[g].funct;
        assign rs[5*g +: 5]     = m_fields_q[g].rs;
        assign rt[5*g +: 5]     = m_fields_q[g].rt;
        assign rd[5*g +: 5]     = m_fields_q[g].rd;
        assign sa[5*g +: 5]     = m_fields_q[g].sa;
        assign imm[32*g +: 32]  = m_fields_q[g].imm;
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != StEmpty);
    assign lane_valid  = m_mask_q;
    assign pcplus4_out = m_pc_q;

    // Occupancy next state and which register loads from where.
    always_comb begin
        accept    = in_valid && in_ready_q && !flush;
        deliver   = (state_q != StEmpty) && out_ready;
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d   = StOne;
                    load_m_in = 1'b1;
                end
            end
            StOne: begin
                if (accept && deliver) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    state_d = StTwo;
                    load_s  = 1'b1;
                end else if (deliver) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a delivery can happen.
                if (deliver) begin
                    state_d  = StOne;
                    load_m_s = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
    end

    // State, registered ready, and the main/skid entries.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            m_fields_q <= '0;
            s_fields_q <= '0;
            m_mask_q   <= '0;
            s_mask_q   <= '0;
            m_pc_q     <= '0;
            s_pc_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StTwo);
            if (load_m_in) begin
                m_fields_q <= in_fields;
                m_mask_q   <= lane_mask_in;
                m_pc_q     <= pcplus4_in;
            end else if (load_m_s) begin
                m_fields_q <= s_fields_q;
                m_mask_q   <= s_mask_q;
                m_pc_q     <= s_pc_q;
            end
            if (load_s) begin
                s_fields_q <= in_fields;
                s_mask_q   <= lane_mask_in;
                s_pc_q     <= pcplus4_in;
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a 2-lane zero-extending instance plus a 1-lane
// sign-extend-only instance sharing the same handshake inputs.
module tb_if_id_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] instr_in = '0;
    logic [1:0]  lane_mask_in = '0;
    logic [31:0] pcplus4_in = '0;

    logic        in_ready, out_valid;
    logic [1:0]  lane_valid;
    logic [31:0] pcplus4_out;
    logic [11:0] op, funct;
    logic [9:0]  rs, rt, rd, sa;
    logic [63:0] imm;

    logic        sx_in_ready, sx_out_valid;
    logic [0:0]  sx_lane_valid;
    logic [31:0] sx_pc;
    logic [5:0]  sx_op, sx_funct;
    logic [4:0]  sx_rs, sx_rt, sx_rd, sx_sa;
    logic [31:0] sx_imm;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    if_id_stage #(.LANES(2), .PC_W(32), .ZEXT_LOGIC(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .lane_mask_in(lane_mask_in), .pcplus4_in(pcplus4_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .lane_valid(lane_valid), .pcplus4_out(pcplus4_out), .op(op), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm(imm)
    );

    if_id_stage #(.LANES(1), .PC_W(32), .ZEXT_LOGIC(1'b0)) dut_sx (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(sx_in_ready),
        .instr_in(instr_in[31:0]), .lane_mask_in(lane_mask_in[0:0]),
        .pcplus4_in(pcplus4_in), .flush(flush), .out_valid(sx_out_valid),
        .out_ready(out_ready), .lane_valid(sx_lane_valid), .pcplus4_out(sx_pc),
        .op(sx_op), .funct(sx_funct), .rs(sx_rs), .rt(sx_rt), .rd(sx_rd), .sa(sx_sa),
        .imm(sx_imm)
    );

    typedef struct {
        logic [31:0] i0, i1;
        logic [1:0]  mask;
        logic [31:0] pc;
        logic [5:0]  op0;
        logic [4:0]  rs0, rt0;
        logic [31:0] imm0, imm1, imm_sx;
    } vec_t;

    typedef struct {
        logic [63:0] ins;
        logic [1:0]  mask;
        logic [31:0] pc;
    } bund_t;

    vec_t  vecs[5];
    bund_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference immediate: 16-bit value widened arithmetically.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input bit zext);
        int unsigned o;
        int unsigned lo;
        o  = ins >> 26;
        lo = ins & 32'h0000FFFF;
        if (zext && o >= 12 && o <= 14) return lo;
        if (lo >= 32768) return lo + 32'hFFFF0000;
        return lo;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 2) == 0) r[31:26] = 6'h0C + 6'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic offer(input logic [31:0] i0);
        in_valid   = 1'b1;
        instr_in   = {32'h0, i0};
        lane_mask_in = 2'b01;
        pcplus4_in = i0 + 32'd4;
    endtask

    initial begin
        vecs[0] = '{32'h2008FFFF, 32'h3108FFFF, 2'b01, 32'h4, 6'h08, 5'd0, 5'd8,
                    32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF};
        vecs[1] = '{32'h3108FFFF, 32'h2008FFFF, 2'b10, 32'h8, 6'h0C, 5'd8, 5'd8,
                    32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2] = '{32'h34A51234, 32'h38008000, 2'b11, 32'h100, 6'h0D, 5'd5, 5'd5,
                    32'h00001234, 32'h00008000, 32'h00001234};
        vecs[3] = '{32'h38008000, 32'h3C018000, 2'b00, 32'hFFFFFFFC, 6'h0E, 5'd0, 5'd0,
                    32'h00008000, 32'hFFFF8000, 32'hFFFF8000};
        vecs[4] = '{32'h8C22FFF0, 32'h28000001, 2'b11, 32'h1234, 6'h23, 5'd1, 5'd2,
                    32'hFFFFFFF0, 32'h00000001, 32'hFFFFFFF0};

        // Reset for two cycles with an offer pending.
        RESET = 1'b1; in_valid = 1'b1; instr_in = 64'h2008FFFF_3108FFFF;
        lane_mask_in = 2'b11; pcplus4_in = 32'h40;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imm", imm[31:0] | imm[63:32], 32'd0);
        chk("rst_fields", {op, funct, sa[1:0]} | {rs, rt, rd, sa[9:8]}, 32'd0);
        chk("rst_pc_mask", pcplus4_out | 32'(lane_valid), 32'd0);
        RESET = 1'b0; in_valid = 1'b0;

        // Table vectors: one bundle each, out_ready high.
        for (int v = 0; v < 5; v++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            instr_in = {vecs[v].i1, vecs[v].i0};
            lane_mask_in = vecs[v].mask; pcplus4_in = vecs[v].pc;
            tick();
            in_valid = 1'b0;
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_op0", 32'(op[5:0]), 32'(vecs[v].op0));
            chk("vec_rs0", 32'(rs[4:0]), 32'(vecs[v].rs0));
            chk("vec_rt0", 32'(rt[4:0]), 32'(vecs[v].rt0));
            chk("vec_imm0", imm[31:0], vecs[v].imm0);
            chk("vec_imm1", imm[63:32], vecs[v].imm1);
            chk("vec_imm_sx", sx_imm, vecs[v].imm_sx);
            chk("vec_lane_valid", 32'(lane_valid), 32'(vecs[v].mask));
            chk("vec_pc", pcplus4_out, vecs[v].pc);
            tick();
            chk("vec_drained", 32'(out_valid), 32'd0);
        end

        // Back-pressure: A then B with out_ready low.
        out_ready = 1'b0;
        offer(32'h20010001); tick();
        chk("bp_a_valid", 32'(out_valid), 32'd1);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        offer(32'h20020002); tick();
        in_valid = 1'b0;
        chk("bp_two_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_a", imm[31:0], 32'h00000001);
        tick();
        chk("bp_still_ready", 32'(in_ready), 32'd0);
        chk("bp_still_a_pc", pcplus4_out, 32'h20010005);
        out_ready = 1'b1; tick();
        chk("bp_b_out", imm[31:0], 32'h00000002);
        chk("bp_b_ready", 32'(in_ready), 32'd1);
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush while holding two bundles with C offered.
        out_ready = 1'b0;
        offer(32'h20010001); tick();
        offer(32'h20020002); tick();
        offer(32'h20030003); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_two_valid", 32'(out_valid), 32'd0);
        chk("fl_two_ready", 32'(in_ready), 32'd1);
        tick();
        chk("fl_c_absent", 32'(out_valid), 32'd0);

        // Flush in ONE drops a ready-accepted offer; next offer accepted.
        offer(32'h20010001); tick();
        offer(32'h20030003); flush = 1'b1; out_ready = 1'b1; tick();
        flush = 1'b0;
        chk("fl_one_valid", 32'(out_valid), 32'd0);
        offer(32'h20040004); tick();
        in_valid = 1'b0;
        chk("fl_after_valid", 32'(out_valid), 32'd1);
        chk("fl_after_imm", imm[31:0], 32'h00000004);
        tick();

        // Reset mid-stream discards both entries.
        out_ready = 1'b0;
        offer(32'h20010001); tick();
        offer(32'h20020002); tick();
        RESET = 1'b1; tick();
        RESET = 1'b0; in_valid = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        chk("mrst_imm", imm[31:0], 32'd0);

        // Random traffic against a queue model.
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            bit dlv, acc;
            RESET        = ($urandom_range(0, 99) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            instr_in     = {rand_instr(), rand_instr()};
            lane_mask_in = 2'($urandom);
            pcplus4_in   = $urandom();

            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("rnd_sx_valid", 32'(sx_out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_pc", pcplus4_out, q[0].pc);
                chk("rnd_mask", 32'(lane_valid), 32'(q[0].mask));
                chk("rnd_imm_sx", sx_imm, ref_imm(q[0].ins[31:0], 1'b0));
                for (int l = 0; l < 2; l++) begin
                    logic [31:0] ins;
                    ins = q[0].ins[32*l +: 32];
                    chk("rnd_op", 32'(op[6*l +: 6]), ins >> 26);
                    chk("rnd_rs", 32'(rs[5*l +: 5]), (ins >> 21) & 32'h1F);
                    chk("rnd_rt", 32'(rt[5*l +: 5]), (ins >> 16) & 32'h1F);
                    chk("rnd_rd", 32'(rd[5*l +: 5]), (ins >> 11) & 32'h1F);
                    chk("rnd_sa", 32'(sa[5*l +: 5]), (ins >> 6) & 32'h1F);
                    chk("rnd_funct", 32'(funct[6*l +: 6]), ins & 32'h3F);
                    chk("rnd_imm", imm[32*l +: 32], ref_imm(ins, 1'b1));
                end
            end

            if (RESET) begin
                q.delete();
            end else begin
                dlv = (q.size() > 0) && out_ready;
                acc = in_valid && (q.size() < 2) && !flush;
                if (dlv) void'(q.pop_front());
                if (flush) q.delete();
                if (acc) q.push_back('{instr_in, lane_mask_in, pcplus4_in});
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
